data_plane_tx: RTL

- Transmit side of the data plane; sits directly upstream of data_plane_rx.
- The GPP pushes 16-bit data words into a local TX FIFO.
- On a start strobe from the control plane (path granted), the block emits a fixed-length burst of 32-bit packets {dest_id[31:16], data[15:0]} onto the data plane, one per cycle, then pulses a completion flag.
- Between bursts it drives an idle packet whose ID field matches no node.

---
 rtl/dp_pkg.sv | 28 ++
 rtl/dp_tx_fifo.sv | 50 +++++
 rtl/data_plane_tx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Data-plane shared constants and types.
// data_plane_tx and data_plane_rx both build on these.
package dp_pkg;

  localparam logic [15:0] DP_IDLE_ID   = 16'hFFFF;
  localparam int          DP_BURST_LEN = 5;

  typedef struct packed {
    logic [15:0] dest;
    logic [15:0] data;
  } dp_packet_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } dp_tx_state_t;

  function automatic dp_packet_t dp_idle_pkt(
    input logic [15:0] id
  );
    dp_packet_t p;
    p.dest = id;
    p.data = 16'h0000;
    return p;
  endfunction

endpackage

// File: rtl/dp_tx_fifo.sv
// TX word FIFO: DEPTH x W, first-in first-out.
// A push while full is dropped; a pop while empty is ignored.
module dp_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/data_plane_tx.sv
// Data-plane transmitter: buffers GPP words and emits
// fixed-length {dest, data} bursts on a control-plane grant.
module data_plane_tx
  import dp_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          BURST_LEN = DP_BURST_LEN,
  parameter logic [15:0] IDLE_ID   = DP_IDLE_ID
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     gpp_wr_dp,
  input  logic [15:0]              gpp_tx_data,
  input  logic [15:0]              dest_id,
  input  logic                     tx_start,
  output logic [31:0]              data_tx_packet,
  output logic                     data_tx_busy,
  output logic                     data_tx_complete_flag,
  output logic                     tx_full,
  output logic [$clog2(DEPTH):0]   tx_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  dp_tx_state_t  state;
  dp_tx_state_t  state_d;
  dp_packet_t    pkt_q;
  dp_packet_t    pkt_d;
  logic [15:0]   dest_q;
  logic [15:0]   dest_d;
  logic [BW-1:0] beat_q;
  logic [BW-1:0] beat_d;
  logic          busy_q;
  logic          busy_d;
  logic          cmp_q;
  logic          cmp_d;
  logic          pop;
  logic          fifo_empty;
  logic [15:0]   head;
  logic          accept;
  logic          last_beat;

  dp_tx_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gpp_wr_dp),
    .din   (gpp_tx_data),
    .pop   (pop),
    .dout  (head),
    .count (tx_count),
    .full  (tx_full),
    .empty (fifo_empty)
  );

  // The idle ID can never be a receiver, so it is refused as a target.
  assign accept = tx_start
               && (tx_count >= CW'(BURST_LEN))
               && (dest_id != IDLE_ID);

  assign last_beat = beat_q == BW'(BURST_LEN - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_d  = pkt_q;
    dest_d = dest_q;
    beat_d = beat_q;
    busy_d = busy_q;
    cmp_d  = 1'b0;
    pop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          dest_d = dest_id;
          beat_d = '0;
          busy_d = 1'b1;
        end
      end
      SEND: begin
        pkt_d.dest = dest_q;
        pkt_d.data = head;
        pop        = !fifo_empty;
        beat_d     = beat_q + 1'b1;
      end
      DONE: begin
        pkt_d  = dp_idle_pkt(IDLE_ID);
        cmp_d  = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        pkt_d  = dp_idle_pkt(IDLE_ID);
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q  <= dp_idle_pkt(IDLE_ID);
      dest_q <= '0;
      beat_q <= '0;
      busy_q <= 1'b0;
      cmp_q  <= 1'b0;
    end else begin
      pkt_q  <= pkt_d;
      dest_q <= dest_d;
      beat_q <= beat_d;
      busy_q <= busy_d;
      cmp_q  <= cmp_d;
    end
  end

  assign data_tx_packet        = pkt_q;
  assign data_tx_busy          = busy_q;
  assign data_tx_complete_flag = cmp_q;

endmodule
